wr_skid_buf: RTL and testbench

WR_SKID_BUF -- requirements
Module: wr_skid_buf

---
 rtl/wr_skid_buf.sv | 138 +++++++++++++
 tb/tb_wr_skid_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_skid_buf.sv
// wr_skid_buf: two-entry skid buffer in front of the write side of an async FIFO.
// Words accepted on the s_valid/s_ready handshake are pushed in order to the FIFO
// write stage through winc/wdata; s_ready is registered, so the spare slot absorbs
// the word that arrives in the cycle wfull stalls the head.
// Ports:
//   wclk, wrst_n      clock, synchronous active-low reset
//   s_valid, s_data, s_last, s_ready   upstream handshake (s_ready registered)
//   wfull             FIFO full flag (combinationally gates winc)
//   winc, wdata       FIFO write strobe and data (combinational from state)
//   pkt_cnt           packets whose last word has been pushed (wraps)
// Optional feature: define WR_SKID_STATS_EN to add saturating word_cnt/stall_cnt.
module wr_skid_buf #(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned CNTSIZE = 16
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               s_valid,
    input  logic [DSIZE-1:0]   s_data,
    input  logic               s_last,
    output logic               s_ready,
    input  logic               wfull,
    output logic               winc,
    output logic [DSIZE-1:0]   wdata,
    output logic [CNTSIZE-1:0] pkt_cnt
`ifdef WR_SKID_STATS_EN
    ,
    output logic [CNTSIZE-1:0] word_cnt,
    output logic [CNTSIZE-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [DSIZE-1:0]   h_data;
    logic [DSIZE-1:0]   h_data_nxt;
    logic               h_last;
    logic               h_last_nxt;
    logic [DSIZE-1:0]   sp_data;
    logic [DSIZE-1:0]   sp_data_nxt;
    logic               sp_last;
    logic               sp_last_nxt;
    logic [CNTSIZE-1:0] pkt_cnt_nxt;
    logic               accept;

    // Write strobe and data come straight from the head slot.
    assign winc   = (state != ST_EMPTY) && !wfull;
    assign wdata  = h_data;
    assign accept = s_valid && s_ready;

    // Next-state and slot-update logic.
    always_comb begin
        state_nxt   = state;
        h_data_nxt  = h_data;
        h_last_nxt  = h_last;
        sp_data_nxt = sp_data;
        sp_last_nxt = sp_last;
        pkt_cnt_nxt = pkt_cnt;

        if (winc && h_last) begin
            pkt_cnt_nxt = pkt_cnt + CNTSIZE'(1);
        end

        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt  = ST_ONE;
                    h_data_nxt = s_data;
                    h_last_nxt = s_last;
                end
            end
            ST_ONE: begin
                if (accept && winc) begin
                    h_data_nxt = s_data;
                    h_last_nxt = s_last;
                end else if (accept) begin
                    state_nxt   = ST_TWO;
                    sp_data_nxt = s_data;
                    sp_last_nxt = s_last;
                end else if (winc) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only the head can move.
                if (winc) begin
                    state_nxt  = ST_ONE;
                    h_data_nxt = sp_data;
                    h_last_nxt = sp_last;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // State and slot registers.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state   <= ST_EMPTY;
            s_ready <= 1'b0;
            pkt_cnt <= '0;
            h_data  <= '0;
            h_last  <= 1'b0;
            sp_data <= '0;
            sp_last <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt != ST_TWO);
            pkt_cnt <= pkt_cnt_nxt;
            h_data  <= h_data_nxt;
            h_last  <= h_last_nxt;
            sp_data <= sp_data_nxt;
            sp_last <= sp_last_nxt;
        end
    end

`ifdef WR_SKID_STATS_EN
    // Saturating push and stall counters.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (winc && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNTSIZE'(1);
            end
            if ((state != ST_EMPTY) && wfull && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTSIZE'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_wr_skid_buf.sv
// Self-checking bench for wr_skid_buf: directed vector table, hand sequences for
// stall/reset/packet-count corners, then random traffic against a queue model.
// A second instance with CNTSIZE=2 shares the stimulus to exercise counter wrap
// and saturation.
module tb_wr_skid_buf;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       wfull;
    logic       s_ready, s_ready2;
    logic       winc, winc2;
    logic [7:0] wdata, wdata2;
    logic [15:0] pkt_cnt;
    logic [1:0]  pkt_cnt2;
`ifdef WR_SKID_STATS_EN
    logic [15:0] word_cnt, stall_cnt;
    logic [1:0]  word_cnt2, stall_cnt2;
`endif

    always #5 wclk = ~wclk;

    wr_skid_buf #(.DSIZE(8), .CNTSIZE(16)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .pkt_cnt(pkt_cnt)
`ifdef WR_SKID_STATS_EN
        , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
    );

    wr_skid_buf #(.DSIZE(8), .CNTSIZE(2)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready2), .wfull(wfull), .winc(winc2),
        .wdata(wdata2), .pkt_cnt(pkt_cnt2)
`ifdef WR_SKID_STATS_EN
        , .word_cnt(word_cnt2), .stall_cnt(stall_cnt2)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: words held in the buffer as {last, data}, in order.
    logic [8:0]  q[$];
    logic        m_ready;
    int unsigned m_pkt, m_word, m_stall;

    // Values sampled at the last negedge of step().
    logic        smp_ready, smp_winc;
    logic [7:0]  smp_wdata;
    int unsigned smp_pkt, smp_pkt2, smp_word, smp_stall, smp_word2, smp_stall2;

    typedef struct {
        logic r, v; logic [7:0] d; logic l, f;
        logic e_ready, e_winc; logic [7:0] e_wdata; int e_pkt;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input logic r, v, input logic [7:0] d, input logic l, f);
        wrst_n = r; s_valid = v; s_data = d; s_last = l; wfull = f;
    endtask

    // Compare DUT outputs with the model; called mid-cycle.
    task automatic model_check();
        logic e_winc;
        e_winc = (q.size() > 0) && !wfull;
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("winc", 32'(winc), 32'(e_winc));
        if (e_winc) chk("wdata", 32'(wdata), 32'(q[0][7:0]));
        chk("pkt_cnt", 32'(pkt_cnt), m_pkt % 65536);
        chk("pkt_cnt_w2", 32'(pkt_cnt2), m_pkt % 4);
        chk("winc_w2", 32'(winc2), 32'(e_winc));
`ifdef WR_SKID_STATS_EN
        chk("word_cnt", 32'(word_cnt), sat(m_word, 65535));
        chk("stall_cnt", 32'(stall_cnt), sat(m_stall, 65535));
        chk("word_cnt_w2", 32'(word_cnt2), sat(m_word, 3));
        chk("stall_cnt_w2", 32'(stall_cnt2), sat(m_stall, 3));
`endif
        smp_ready = s_ready; smp_winc = winc; smp_wdata = wdata;
        smp_pkt = 32'(pkt_cnt); smp_pkt2 = 32'(pkt_cnt2);
`ifdef WR_SKID_STATS_EN
        smp_word = 32'(word_cnt); smp_stall = 32'(stall_cnt);
        smp_word2 = 32'(word_cnt2); smp_stall2 = 32'(stall_cnt2);
`else
        smp_word = 0; smp_stall = 0; smp_word2 = 0; smp_stall2 = 0;
`endif
    endtask

    // Advance the model across a clock edge using the inputs currently driven.
    task automatic model_update();
        logic acc, psh;
        if (!wrst_n) begin
            q.delete();
            m_ready = 1'b0; m_pkt = 0; m_word = 0; m_stall = 0;
        end else begin
            acc = s_valid && m_ready;
            psh = (q.size() > 0) && !wfull;
            if ((q.size() > 0) && wfull) m_stall++;
            if (psh) begin
                if (q[0][8]) m_pkt++;
                m_word++;
                void'(q.pop_front());
            end
            if (acc) q.push_back({s_last, s_data});
            m_ready = (q.size() != 2);
        end
    endtask

    task automatic step(input logic r, v, input logic [7:0] d, input logic l, f);
        drive(r, v, d, l, f);
        @(negedge wclk);
        model_check();
        @(posedge wclk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge wclk);
        model_update();
        @(posedge wclk);
        model_update();
        #1;
    endtask

    task automatic row(input int i, input logic r, v, input logic [7:0] d, input logic l, f,
                       input logic er, ew, input logic [7:0] ewd, input int ep);
        tbl[i].r = r; tbl[i].v = v; tbl[i].d = d; tbl[i].l = l; tbl[i].f = f;
        tbl[i].e_ready = er; tbl[i].e_winc = ew; tbl[i].e_wdata = ewd; tbl[i].e_pkt = ep;
    endtask

    initial begin
        // Reset, 8-word burst, then a 5-cycle wfull stall that fills both slots.
        row( 0, 0,0,8'h00,0,0, 0,0,8'h00,0);
        row( 1, 1,1,8'h01,0,0, 0,0,8'h00,0);
        row( 2, 1,1,8'h01,0,0, 1,0,8'h00,0);
        row( 3, 1,1,8'h02,0,0, 1,1,8'h01,0);
        row( 4, 1,1,8'h03,1,0, 1,1,8'h02,0);
        row( 5, 1,1,8'h04,0,0, 1,1,8'h03,0);
        row( 6, 1,1,8'h05,0,0, 1,1,8'h04,1);
        row( 7, 1,1,8'h06,0,0, 1,1,8'h05,1);
        row( 8, 1,1,8'h07,0,0, 1,1,8'h06,1);
        row( 9, 1,1,8'h08,1,0, 1,1,8'h07,1);
        row(10, 1,0,8'h00,0,0, 1,1,8'h08,1);
        row(11, 1,1,8'hA1,0,0, 1,0,8'h00,2);
        row(12, 1,1,8'hA2,0,1, 1,0,8'h00,2);
        row(13, 1,1,8'hEE,1,1, 0,0,8'h00,2);
        row(14, 1,1,8'hEE,1,1, 0,0,8'h00,2);
        row(15, 1,1,8'hEE,1,1, 0,0,8'h00,2);
        row(16, 1,1,8'hEE,1,1, 0,0,8'h00,2);
        row(17, 1,1,8'hEE,1,0, 0,1,8'hA1,2);
        row(18, 1,1,8'hA3,1,0, 1,1,8'hA2,2);
        row(19, 1,0,8'h00,0,0, 1,1,8'hA3,2);
        row(20, 1,0,8'h00,0,0, 1,0,8'h00,3);

        m_ready = 1'b0; m_pkt = 0; m_word = 0; m_stall = 0;
        #1;
        do_reset();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
            @(negedge wclk);
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_winc", i), 32'(winc), 32'(tbl[i].e_winc));
            if (tbl[i].e_winc) chk($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'(tbl[i].e_wdata));
            chk($sformatf("tbl%0d_pkt", i), 32'(pkt_cnt), 32'(tbl[i].e_pkt));
            model_check();
            @(posedge wclk);
            model_update();
            #1;
        end

        // Reset while both slots are occupied: held words must never reach wdata.
        step(1,1,8'hB1,0,0);
        step(1,1,8'hB2,1,1);
        step(1,1,8'hB3,1,1);
        chk("two_ready", 32'(smp_ready), 0);
        step(0,0,8'h00,0,1);
        step(1,0,8'h00,0,0);
        chk("rst_winc", 32'(smp_winc), 0);
        chk("rst_ready", 32'(smp_ready), 0);
        chk("rst_pkt", smp_pkt, 0);
        for (int i = 0; i < 3; i++) begin
            step(1,0,8'h00,0,0);
            chk("rst_no_stale_winc", 32'(smp_winc), 0);
        end

        // Packets of 3, 1, 4 words, then two more to wrap the 2-bit counter.
        do_reset();
        step(1,0,8'h00,0,0);
        begin
            int lens[5] = '{3, 1, 4, 2, 1};
            for (int p = 0; p < 5; p++) begin
                for (int w = 0; w < lens[p]; w++)
                    step(1,1,8'(p*16+w),(w == lens[p]-1),0);
                if (p == 2) begin
                    step(1,0,8'h00,0,0);
                    step(1,0,8'h00,0,0);
                    chk("pkt_after_3", smp_pkt, 3);
                end
            end
        end
        step(1,0,8'h00,0,0);
        step(1,0,8'h00,0,0);
        chk("pkt_after_5", smp_pkt, 5);
        chk("pkt_w2_after_5", smp_pkt2, 1);

`ifdef WR_SKID_STATS_EN
        // 10 pushes with 4 stalled cycles.
        do_reset();
        step(1,0,8'h00,0,0);
        for (int i = 0; i < 5; i++) step(1,1,8'(i),0,0);
        for (int i = 0; i < 4; i++) step(1,1,8'hEE,0,1);
        for (int i = 0; i < 3; i++) step(1,0,8'h00,0,0);
        for (int i = 0; i < 4; i++) step(1,1,8'(8'h40+i),0,0);
        step(1,0,8'h00,0,0);
        step(1,0,8'h00,0,0);
        chk("word_cnt_10", smp_word, 10);
        chk("stall_cnt_4", smp_stall, 4);
        chk("word_cnt_sat", smp_word2, 3);
        chk("stall_cnt_sat", smp_stall2, 3);
`endif

        // Random traffic with occasional reset.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 4; i++) step(1,0,8'h00,0,0);
        chk("drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
